sobel_frame_packer: RTL

SOBEL_FRAME_PACKER -- requirements
Module: sobel_frame_packer

---
 rtl/sobel_frame_packer.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/sobel_frame_packer.sv
// sobel_frame_packer
//   Packs a Sobel-filtered image into a byte stream for a UART transmitter:
//   a 5-byte header (0xA5, width LE, height LE), width*height payload bytes
//   drawn from an internal FIFO, and a one-byte XOR checksum trailer.
//   Pixels that arrive while the FIFO is full are dropped, flagged on the
//   sticky overflow output, and replaced by 0x00 in the outgoing frame.
//
// Ports
//   clk, rst            : single clock, synchronous active-high reset
//   start               : one-cycle pulse, begins a frame when idle
//   width, height       : image dimensions, sampled on an accepted start
//   data_in/valid_in    : pixel input, handshaked with ready_in
//   data_out/valid_out  : registered byte output, handshaked with ready_out
//   busy                : frame in progress
//   overflow            : sticky, a pixel was dropped this frame
//   frame_done          : one-cycle pulse after the trailer byte is taken
module sobel_frame_packer #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [15:0]          width,
    input  logic [15:0]          height,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid_in,
    output logic                 ready_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready_out,
    output logic                 busy,
    output logic                 overflow,
    output logic                 frame_done
);

    localparam int unsigned    AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    FULL_LEVEL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0]  PTR_ONE    = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_TRAILER
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [15:0]           r_width;
    logic [15:0]           r_height;
    logic [31:0]           r_total;
    logic [31:0]           r_in_count;
    logic [31:0]           r_out_count;
    logic [2:0]            r_hdr_idx;
    logic                  r_trl_loaded;
    logic [DATA_BITS-1:0]  r_checksum;
    logic [31:0]           r_zero_pend;
    logic                  r_overflow;
    logic                  r_frame_done;
    logic [DATA_BITS-1:0]  r_data_out;
    logic                  r_valid_out;

    // Payload FIFO. Each slot also records how many dropped pixels
    // followed it, so the reader can insert that many 0x00 bytes right
    // after emitting the slot and keep the frame in arrival order.
    logic [DATA_BITS-1:0]  r_mem   [FIFO_DEPTH];
    logic [31:0]           r_zeros [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_in_open;
    logic                  w_ready_in;
    logic                  w_accept;
    logic                  w_drop;
    logic                  w_load_en;
    logic                  w_xfer;
    logic                  w_start_acc;
    logic                  w_have_byte;
    logic [DATA_BITS-1:0]  w_next_byte;
    logic                  w_hdr_load;
    logic                  w_payload_load;
    logic                  w_pop;
    logic                  w_zero_emit;
    logic                  w_trl_load;
    logic                  w_done_xfer;

    assign w_full      = (r_count == FULL_LEVEL);
    assign w_empty     = (r_count == '0);
    assign w_in_open   = (r_state != S_IDLE) && (r_in_count < r_total);
    assign w_ready_in  = w_in_open && !w_full;
    assign w_accept    = valid_in && w_ready_in;
    // A drop needs a full FIFO, so the tail slot always exists and is never
    // the head being popped in the same cycle (depth >= 4).
    assign w_drop      = valid_in && w_in_open && w_full;
    assign w_load_en   = !r_valid_out || ready_out;
    assign w_xfer      = r_valid_out && ready_out;
    assign w_start_acc = (r_state == S_IDLE) && start;

    // Next-state and output-register source selection
    always_comb begin
        w_state_next   = r_state;
        w_have_byte    = 1'b0;
        w_next_byte    = '0;
        w_hdr_load     = 1'b0;
        w_payload_load = 1'b0;
        w_pop          = 1'b0;
        w_zero_emit    = 1'b0;
        w_trl_load     = 1'b0;
        w_done_xfer    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_HEADER;
                end
            end

            S_HEADER: begin
                w_have_byte = 1'b1;
                case (r_hdr_idx)
                    3'd0:    w_next_byte = DATA_BITS'(8'hA5);
                    3'd1:    w_next_byte = DATA_BITS'(r_width[7:0]);
                    3'd2:    w_next_byte = DATA_BITS'(r_width[15:8]);
                    3'd3:    w_next_byte = DATA_BITS'(r_height[7:0]);
                    default: w_next_byte = DATA_BITS'(r_height[15:8]);
                endcase
                if (w_load_en) begin
                    w_hdr_load = 1'b1;
                    if (r_hdr_idx == 3'd4) begin
                        w_state_next = (r_total == '0) ? S_TRAILER : S_PAYLOAD;
                    end
                end
            end

            S_PAYLOAD: begin
                // Zeros owed to the previously popped slot come before the
                // next FIFO entry.
                if (r_zero_pend != '0) begin
                    w_have_byte = 1'b1;
                    w_next_byte = '0;
                    w_zero_emit = w_load_en;
                end else if (!w_empty) begin
                    w_have_byte = 1'b1;
                    w_next_byte = r_mem[r_rd_ptr];
                    w_pop       = w_load_en;
                end
                if (w_load_en && w_have_byte) begin
                    w_payload_load = 1'b1;
                    if ((r_out_count + 32'd1) == r_total) begin
                        w_state_next = S_TRAILER;
                    end
                end
            end

            S_TRAILER: begin
                if (!r_trl_loaded) begin
                    w_have_byte = 1'b1;
                    w_next_byte = r_checksum;
                    w_trl_load  = w_load_en;
                end else if (w_xfer) begin
                    w_done_xfer  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FIFO storage, no reset needed: occupancy is tracked by r_count
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr]   <= data_in;
            r_zeros[r_wr_ptr] <= '0;
        end else if (w_drop) begin
            r_zeros[r_wr_ptr - PTR_ONE] <= r_zeros[r_wr_ptr - PTR_ONE] + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_width      <= '0;
            r_height     <= '0;
            r_total      <= '0;
            r_in_count   <= '0;
            r_out_count  <= '0;
            r_hdr_idx    <= '0;
            r_trl_loaded <= 1'b0;
            r_checksum   <= '0;
            r_zero_pend  <= '0;
            r_overflow   <= 1'b0;
            r_frame_done <= 1'b0;
            r_data_out   <= '0;
            r_valid_out  <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
        end else begin
            r_frame_done <= w_done_xfer;

            if (w_load_en) begin
                r_valid_out <= w_have_byte;
                if (w_have_byte) begin
                    r_data_out <= w_next_byte;
                end
            end

            if (w_start_acc) begin
                r_width      <= width;
                r_height     <= height;
                r_total      <= {16'h0, width} * {16'h0, height};
                r_in_count   <= '0;
                r_out_count  <= '0;
                r_hdr_idx    <= '0;
                r_trl_loaded <= 1'b0;
                r_checksum   <= '0;
                r_zero_pend  <= '0;
                r_overflow   <= 1'b0;
                r_wr_ptr     <= '0;
                r_rd_ptr     <= '0;
                r_count      <= '0;
            end else begin
                if (w_accept || w_drop) begin
                    r_in_count <= r_in_count + 32'd1;
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
                if (w_accept) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr    <= r_rd_ptr + PTR_ONE;
                    r_zero_pend <= r_zeros[r_rd_ptr];
                end else if (w_zero_emit) begin
                    r_zero_pend <= r_zero_pend - 32'd1;
                end
                case ({w_accept, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
                if (w_hdr_load) begin
                    r_hdr_idx <= r_hdr_idx + 3'd1;
                end
                if (w_payload_load) begin
                    r_out_count <= r_out_count + 32'd1;
                    r_checksum  <= r_checksum ^ w_next_byte;
                end
                if (w_trl_load) begin
                    r_trl_loaded <= 1'b1;
                end
            end
        end
    end

    assign ready_in   = w_ready_in;
    assign data_out   = r_data_out;
    assign valid_out  = r_valid_out;
    assign busy       = (r_state != S_IDLE);
    assign overflow   = r_overflow;
    assign frame_done = r_frame_done;

endmodule
